// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the four-channel dithered PWM DAC.
// Config word layout: [23:16] base duty, [15:0] dither pattern (one bit per slot).
package pwm_dac_pkg;

  localparam int FULL_DEF = 156;
  localparam int CFG_W    = 24;
  localparam int DITHER_W = 16;
  localparam int SLOT_W   = 4;
  localparam int CNT_W    = 8;
  localparam int BASE_MSB = 23;
  localparam int BASE_LSB = 16;
  localparam int DUTY_W   = CNT_W + 1;

  // The carry bit lets base 255 plus a dither bit reach 256 without wrapping.
  function automatic logic [DUTY_W-1:0] duty_calc(input logic [CFG_W-1:0]  word,
                                                  input logic [SLOT_W-1:0] slot);
    return {1'b0, word[BASE_MSB:BASE_LSB]} + DUTY_W'(word[slot]);
  endfunction

endpackage

// File: rtl/pwm_dac_ch.sv
// One PWM channel: shadow register loaded on superframe boundaries,
// dithered duty computation and registered comparator output.
module pwm_dac_ch
  import pwm_dac_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [CNT_W-1:0]  v_cnt,
  input  logic [SLOT_W-1:0] b_cnt,
  input  logic              load,
  input  logic [CFG_W-1:0]  cfg,
  output logic              pwm
);

  logic [CFG_W-1:0]  shadow;
  logic [DUTY_W-1:0] duty;

  assign duty = duty_calc(shadow, b_cnt);

  // Duty values at or above the period length simply never fail the compare.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load) shadow <= cfg;
      pwm <= ({1'b0, v_cnt} < duty);
    end
  end

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// Four-channel dithered PWM DAC: shared period/slot counters, boundary load
// strobe and superframe sync; one pwm_dac_ch instance per output pin.
module red_pitaya_pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int FULL = FULL_DEF
)(
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [CFG_W-1:0] cfg_a_i,
  input  logic [CFG_W-1:0] cfg_b_i,
  input  logic [CFG_W-1:0] cfg_c_i,
  input  logic [CFG_W-1:0] cfg_d_i,
  output logic [3:0]       pwm_o,
  output logic             sync_o
);

  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(FULL - 1);

  logic [CNT_W-1:0]  v_cnt;
  logic [SLOT_W-1:0] b_cnt;
  logic              load_pend;
  logic              v_wrap;
  logic              load;
  logic [CFG_W-1:0]  cfg [4];

  assign cfg[0] = cfg_a_i;
  assign cfg[1] = cfg_b_i;
  assign cfg[2] = cfg_c_i;
  assign cfg[3] = cfg_d_i;

  assign v_wrap = (v_cnt == V_LAST);
  // load_pend forces a load on the first edge after reset so the first
  // superframe does not run on the cleared shadows.
  assign load   = load_pend | (v_wrap & (b_cnt == '1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v_cnt     <= '0;
      b_cnt     <= '0;
      load_pend <= 1'b1;
      sync_o    <= 1'b0;
    end else begin
      load_pend <= 1'b0;
      v_cnt     <= v_wrap ? '0 : v_cnt + 1'b1;
      if (v_wrap) b_cnt <= b_cnt + 1'b1;
      sync_o    <= (v_cnt == '0) && (b_cnt == '0);
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_ch
    pwm_dac_ch u_ch (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .v_cnt  (v_cnt),
      .b_cnt  (b_cnt),
      .load   (load),
      .cfg    (cfg[n]),
      .pwm    (pwm_o[n])
    );
  end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Self-checking bench: per-cycle comparison against a time-indexed reference
// model plus directed high-time counts and randomized config/reset traffic.
module tb_red_pitaya_pwm_dac;

  localparam int FULL = 156;
  localparam int SF   = 16 * FULL;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [23:0] cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i;
  logic [3:0]  pwm_o;
  logic        sync_o;

  red_pitaya_pwm_dac #(.FULL(FULL)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .cfg_a_i (cfg_a_i),
    .cfg_b_i (cfg_b_i),
    .cfg_c_i (cfg_c_i),
    .cfg_d_i (cfg_d_i),
    .pwm_o   (pwm_o),
    .sync_o  (sync_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  int          t;
  logic [23:0] act [4];
  int          hi_cur  [4][16];
  int          hi_last [4][16];

  // Output after clock edge t since release: period position t%FULL, slot (t/FULL)%16.
  function automatic logic exp_bit(input logic [23:0] w, input int tt);
    int v, s, duty;
    v    = tt % FULL;
    s    = (tt / FULL) % 16;
    duty = int'(w[23:16]) + int'(w[s]);
    return v < duty;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic clear_counts();
    foreach (hi_cur[n, s]) hi_cur[n][s] = 0;
  endtask

  task automatic set_cfg(input int n, input logic [23:0] w);
    case (n)
      0: cfg_a_i = w;
      1: cfg_b_i = w;
      2: cfg_c_i = w;
      default: cfg_d_i = w;
    endcase
  endtask

  task automatic step();
    logic [23:0] cs [4];
    logic [4:0]  e;
    int          s;
    cs = '{cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i};
    @(posedge clk_i);
    #1;
    e[4] = ((t % SF) == 0);
    for (int n = 0; n < 4; n++) e[n] = exp_bit(act[n], t);
    check("cycle", 32'({sync_o, pwm_o}), 32'(e));
    s = (t / FULL) % 16;
    for (int n = 0; n < 4; n++) hi_cur[n][s] += int'(pwm_o[n]);
    if (t == 0 || (t % SF) == SF - 1) act = cs;
    if ((t % SF) == SF - 1) begin
      hi_last = hi_cur;
      clear_counts();
    end
    t++;
  endtask

  task automatic run_sf();
    do step(); while ((t % SF) != 0);
  endtask

  // Called with the bench 1 time unit after a rising edge; release lands mid-cycle.
  task automatic release_rst();
    @(posedge clk_i);
    #4;
    rstn_i = 1'b1;
    t = 0;
    foreach (act[n]) act[n] = '0;
    clear_counts();
  endtask

  task automatic async_reset(input int hold);
    #3;
    rstn_i = 1'b0;
    #1;
    check("rst_async_pwm", 32'(pwm_o), 32'h0);
    check("rst_async_sync", 32'(sync_o), 32'h0);
    repeat (hold) @(posedge clk_i);
    #1;
    check("rst_hold_pwm", 32'(pwm_o), 32'h0);
    release_rst();
  endtask

  function automatic logic [23:0] rand_word();
    case ($urandom_range(0, 3))
      0: return 24'h00_0000;
      1: return 24'hFF_FFFF;
      2: return {8'(FULL - 1), 16'($urandom)};
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    int sum_b;
    t = 0;
    foreach (act[n]) act[n] = '0;
    clear_counts();
    cfg_a_i = 24'($urandom);
    cfg_b_i = 24'($urandom);
    cfg_c_i = 24'($urandom);
    cfg_d_i = 24'($urandom);

    repeat (5) @(posedge clk_i);
    #1;
    check("reset_pwm", 32'(pwm_o), 32'h0);
    check("reset_sync", 32'(sync_o), 32'h0);

    cfg_a_i = 24'h0F_0000;
    cfg_b_i = 24'h4E_0001;
    cfg_c_i = 24'h75_0000;
    cfg_d_i = 24'h00_0000;
    release_rst();
    run_sf();

    repeat (7 * FULL + 50) step();
    cfg_c_i = 24'h9C_FFFF;
    cfg_d_i = 24'hFF_FFFF;
    run_sf();
    check("a_slot0_hi", 32'(hi_last[0][0]), 32'd15);
    check("a_slot9_hi", 32'(hi_last[0][9]), 32'd15);
    check("b_slot0_hi", 32'(hi_last[1][0]), 32'd79);
    check("b_slot5_hi", 32'(hi_last[1][5]), 32'd78);
    sum_b = 0;
    for (int s = 0; s < 16; s++) sum_b += hi_last[1][s];
    check("b_sf_total", 32'(sum_b), 32'd1249);
    check("c_old_slot10", 32'(hi_last[2][10]), 32'd117);
    check("d_zero", 32'(hi_last[3][3]), 32'd0);

    run_sf();
    check("c_clamp_slot0", 32'(hi_last[2][0]), 32'd156);
    check("c_clamp_slot15", 32'(hi_last[2][15]), 32'd156);
    check("d_full_slot8", 32'(hi_last[3][8]), 32'd156);

    cfg_d_i = 24'h9B_8000;
    run_sf();
    run_sf();
    check("d_slot15_full", 32'(hi_last[3][15]), 32'd156);
    check("d_slot0", 32'(hi_last[3][0]), 32'd155);
    check("d_slot7", 32'(hi_last[3][7]), 32'd155);

    repeat (300) step();
    async_reset(3);
    run_sf();
    check("a_after_rst", 32'(hi_last[0][1]), 32'd15);
    check("c_after_rst", 32'(hi_last[2][4]), 32'd156);

    for (int sf = 0; sf < 6; sf++) begin
      do begin
        if ($urandom_range(0, 199) == 0) set_cfg($urandom_range(0, 3), rand_word());
        step();
        if (sf == 3 && (t % SF) == 1000) async_reset($urandom_range(1, 4));
      end while ((t % SF) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
